// File: rtl/mdu_iterative_if.sv
// Issue/result bundle between the execute stage and the iterative multiply/divide unit.
// The pipeline drives the master side; the MDU implements the slave side.
interface mdu_iterative_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;

    modport master (
        output src_a, src_b, start, op,
        input  hi, lo, busy, done
    );

    modport slave (
        input  src_a, src_b, start, op,
        output hi, lo, busy, done
    );
endinterface

// File: rtl/mdu_iterative.sv
// Iterative MDU: radix-2 shift-add multiplier, restoring divider, and the HI/LO registers.
// The MDU_MADD_EN macro adds MADD/MSUB accumulation into HI/LO.
module mdu_iterative #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic           clk,
    input  logic           reset,
    mdu_iterative_if.slave bus
);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;
`ifdef MDU_MADD_EN
    localparam logic [2:0] OP_MADD  = 3'd6;
    localparam logic [2:0] OP_MSUB  = 3'd7;
`endif

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FINISH
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         op_q, op_d;
    logic               neg_res_q, neg_res_d;
    logic               neg_rem_q, neg_rem_d;
    logic               div_zero_q, div_zero_d;
    logic [WIDTH-1:0]   a_raw_q, a_raw_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;

    // Operand conditioning at issue time: sign flags and magnitudes.
    logic               signed_start;
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   mag_a, mag_b;

    assign signed_start = (bus.op == OP_MULT) || (bus.op == OP_DIV)
`ifdef MDU_MADD_EN
                          || (bus.op == OP_MADD) || (bus.op == OP_MSUB)
`endif
                          ;
    assign a_neg = signed_start & bus.src_a[WIDTH-1];
    assign b_neg = signed_start & bus.src_b[WIDTH-1];
    assign mag_a = a_neg ? (~bus.src_a + 1'b1) : bus.src_a;
    assign mag_b = b_neg ? (~bus.src_b + 1'b1) : bus.src_b;

    // Multiply step: acc holds {partial product, remaining multiplier bits}.
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;

    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q};
    assign mul_next = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]}
                               : {1'b0, acc_q[2*WIDTH-1:1]};

    // Divide step: acc holds {remainder, dividend bits / quotient bits}.
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH-1:0]   trial;
    logic               fits;
    logic [2*WIDTH-1:0] div_next;

    assign rem_sh   = acc_q[2*WIDTH-1:WIDTH-1];
    assign fits     = rem_sh >= {1'b0, opnd_q};
    assign trial    = rem_sh[WIDTH-1:0] - opnd_q;
    assign div_next = fits ? {trial, acc_q[WIDTH-2:0], 1'b1}
                           : {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};

    logic               is_div;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quot_f, rem_f;

    assign is_div = (op_q == OP_DIV) || (op_q == OP_DIVU);
    assign prod   = neg_res_q ? (~acc_q + 1'b1) : acc_q;
    assign quot_f = neg_res_q ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
    assign rem_f  = neg_rem_q ? (~acc_q[2*WIDTH-1:WIDTH] + 1'b1) : acc_q[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            op_q       <= '0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            div_zero_q <= 1'b0;
            a_raw_q    <= '0;
            opnd_q     <= '0;
            acc_q      <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            neg_res_q  <= neg_res_d;
            neg_rem_q  <= neg_rem_d;
            div_zero_q <= div_zero_d;
            a_raw_q    <= a_raw_d;
            opnd_q     <= opnd_d;
            acc_q      <= acc_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        neg_res_d  = neg_res_q;
        neg_rem_d  = neg_rem_q;
        div_zero_d = div_zero_q;
        a_raw_d    = a_raw_q;
        opnd_d     = opnd_q;
        acc_d      = acc_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        done_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    case (bus.op)
                        OP_MTHI: hi_d = bus.src_a;
                        OP_MTLO: lo_d = bus.src_a;
                        OP_MULT, OP_MULTU
`ifdef MDU_MADD_EN
                        , OP_MADD, OP_MSUB
`endif
                        : begin
                            op_d      = bus.op;
                            neg_res_d = a_neg ^ b_neg;
                            neg_rem_d = 1'b0;
                            opnd_d    = mag_a;
                            acc_d     = {{WIDTH{1'b0}}, mag_b};
                            cnt_d     = CNT_W'(WIDTH);
                            state_d   = CALC;
                        end
                        OP_DIV, OP_DIVU: begin
                            op_d       = bus.op;
                            neg_res_d  = a_neg ^ b_neg;
                            neg_rem_d  = a_neg;
                            div_zero_d = (bus.src_b == '0);
                            a_raw_d    = bus.src_a;
                            opnd_d     = mag_b;
                            acc_d      = {{WIDTH{1'b0}}, mag_a};
                            cnt_d      = CNT_W'(WIDTH);
                            state_d    = CALC;
                        end
                        default: ;
                    endcase
                end
            end

            CALC: begin
                acc_d = is_div ? div_next : mul_next;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = FINISH;
                end
            end

            FINISH: begin
                state_d = IDLE;
                done_d  = 1'b1;
                if (is_div) begin
                    // A zero divisor bypasses sign fix-up: all-ones quotient, raw dividend as remainder.
                    if (div_zero_q) begin
                        lo_d = '1;
                        hi_d = a_raw_q;
                    end else begin
                        lo_d = quot_f;
                        hi_d = rem_f;
                    end
                end else begin
`ifdef MDU_MADD_EN
                    if (op_q == OP_MADD) begin
                        {hi_d, lo_d} = {hi_q, lo_q} + prod;
                    end else if (op_q == OP_MSUB) begin
                        {hi_d, lo_d} = {hi_q, lo_q} - prod;
                    end else begin
                        {hi_d, lo_d} = prod;
                    end
`else
                    {hi_d, lo_d} = prod;
`endif
                end
            end

            default: state_d = IDLE;
        endcase
    end

    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
    assign bus.busy = (state_q != IDLE);
    assign bus.done = done_q;

endmodule

// File: tb/tb_mdu_iterative.sv
// Randomised and directed bench for mdu_iterative against an arithmetic reference model.
// Define MDU_MADD_EN on both bench and RTL to exercise MADD/MSUB.
module tb_mdu_iterative;

    localparam int W = 32;
`ifdef MDU_MADD_EN
    localparam bit MADD = 1'b1;
`else
    localparam bit MADD = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;
    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;

    always #5 clk = ~clk;

    mdu_iterative_if #(.WIDTH(W)) bus ();

    mdu_iterative #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: plain SV arithmetic on the architectural HI/LO.
    task automatic model_apply(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        longint sa, sb;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            3'd0: begin p = 64'(sa * sb); {m_hi, m_lo} = p; end
            3'd1: begin p = {32'b0, a} * {32'b0, b}; {m_hi, m_lo} = p; end
            3'd2: begin
                if (b == 0) begin m_lo = '1; m_hi = a; end
                else begin m_lo = 32'(sa / sb); m_hi = 32'(sa % sb); end
            end
            3'd3: begin
                if (b == 0) begin m_lo = '1; m_hi = a; end
                else begin m_lo = a / b; m_hi = a % b; end
            end
            3'd4: m_hi = a;
            3'd5: m_lo = a;
            default: begin
                if (MADD) begin
                    p = 64'(sa * sb);
                    if (op == 3'd6) {m_hi, m_lo} = {m_hi, m_lo} + p;
                    else            {m_hi, m_lo} = {m_hi, m_lo} - p;
                end
            end
        endcase
    endtask

    task automatic run_arith(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] h0, l0;
        int cyc, chg;
        h0 = bus.hi;
        l0 = bus.lo;
        bus.start = 1'b1; bus.op = op; bus.src_a = a; bus.src_b = b;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        bus.src_a = $urandom;
        bus.src_b = $urandom;
        cyc = 0;
        chg = 0;
        while (bus.busy === 1'b1 && cyc < 100) begin
            cyc++;
            if (bus.hi !== h0 || bus.lo !== l0 || bus.done !== 1'b0) chg++;
            @(negedge clk);
        end
        model_apply(op, a, b);
        $display("op=%0d a=%h b=%h -> hi=%h lo=%h busy_cycles=%0d", op, a, b, bus.hi, bus.lo, cyc);
        check("busy_cycles", 64'(cyc), 64'(W + 1));
        check("hilo_stable", 64'(chg), 64'd0);
        check("done_rise", 64'(bus.done), 64'd1);
        check("hi", 64'(bus.hi), 64'(m_hi));
        check("lo", 64'(bus.lo), 64'(m_lo));
        @(negedge clk);
        check("done_pulse", 64'(bus.done), 64'd0);
    endtask

    // Moves and disabled ops: single edge, never busy, never done.
    task automatic run_move(input logic [2:0] op, input logic [W-1:0] a);
        bus.start = 1'b1; bus.op = op; bus.src_a = a; bus.src_b = $urandom;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        model_apply(op, a, bus.src_b);
        $display("op=%0d a=%h -> hi=%h lo=%h busy=%0b done=%0b", op, a, bus.hi, bus.lo, bus.busy, bus.done);
        check("move_busy", 64'(bus.busy), 64'd0);
        check("move_done", 64'(bus.done), 64'd0);
        check("move_hi", 64'(bus.hi), 64'(m_hi));
        check("move_lo", 64'(bus.lo), 64'(m_lo));
    endtask

    function automatic logic [W-1:0] rand_opnd();
        case ($urandom_range(0, 6))
            0: return '0;
            1: return 32'h8000_0000;
            2: return '1;
            3: return 32'd1;
            4: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int dn;
        logic [2:0] rop;
        bus.start = 1'b0; bus.op = '0; bus.src_a = '0; bus.src_b = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("rst_hi", 64'(bus.hi), 64'd0);
        check("rst_lo", 64'(bus.lo), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);

        run_move(3'd5, 32'h1234_5678);
        run_move(3'd4, 32'hCAFE_BABE);
        run_arith(3'd0, 32'hFFFF_FFFF, 32'h0000_0002);
        check("mult_hi_const", 64'(bus.hi), 64'hFFFF_FFFF);
        check("mult_lo_const", 64'(bus.lo), 64'hFFFF_FFFE);
        run_arith(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_arith(3'd3, 32'd100, 32'd7);
        run_arith(3'd2, 32'hFFFF_FFF9, 32'd2);
        check("div_neg_lo_const", 64'(bus.lo), 64'hFFFF_FFFD);
        run_arith(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        run_arith(3'd2, 32'd5, 32'd0);
        run_arith(3'd3, 32'hDEAD_BEEF, 32'd0);

`ifdef MDU_MADD_EN
        run_move(3'd4, 32'd0);
        run_move(3'd5, 32'd10);
        run_arith(3'd6, 32'd3, 32'hFFFF_FFFE);
        check("madd_lo_const", 64'(bus.lo), 64'd4);
        run_arith(3'd7, 32'd2, 32'd3);
        check("msub_hi_const", 64'(bus.hi), 64'hFFFF_FFFF);
        check("msub_lo_const", 64'(bus.lo), 64'hFFFF_FFFE);
`else
        run_move(3'd6, 32'h0000_0777);
        run_move(3'd7, 32'h0000_0888);
`endif

        for (int i = 0; i < 24; i++) begin
            rop = 3'($urandom_range(0, 7));
            if (rop < 3'd4 || (rop >= 3'd6 && MADD)) run_arith(rop, rand_opnd(), rand_opnd());
            else run_move(rop, rand_opnd());
        end

        // Abort: DIVU in flight, MTLO while busy, reset at cycle 10.
        run_move(3'd5, 32'h0000_AAAA);
        bus.start = 1'b1; bus.op = 3'd3; bus.src_a = 32'd1000; bus.src_b = 32'd3;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        bus.start = 1'b1; bus.op = 3'd5; bus.src_a = 32'h55;
        @(negedge clk);
        bus.start = 1'b0;
        check("busy_mtlo_ignored", 64'(bus.lo), 64'(m_lo));
        check("busy_still", 64'(bus.busy), 64'd1);
        repeat (6) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        m_hi = '0;
        m_lo = '0;
        $display("abort: after reset hi=%h lo=%h busy=%0b", bus.hi, bus.lo, bus.busy);
        check("abort_hi", 64'(bus.hi), 64'(m_hi));
        check("abort_lo", 64'(bus.lo), 64'(m_lo));
        check("abort_busy", 64'(bus.busy), 64'd0);
        dn = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) dn++;
            @(negedge clk);
        end
        check("abort_no_done", 64'(dn), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
